// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Parametrised pipeline stage register with valid/ready flow control and a
// two-entry skid buffer. Carries one control bundle and one data bundle per
// instruction. Flush squashes everything held, for bubble insertion on a
// redirect. The control output is forced to zero whenever the stage holds no
// valid instruction, so an empty stage never asserts RegWrite/MemWrite/etc.
//
// Ports
//   Clk        clock, all state changes on the rising edge
//   Rst        synchronous active-high reset
//   Flush      synchronous squash of all held entries (and of any offered entry)
//   in_valid   upstream presents an instruction
//   in_ready   stage can accept (registered, a function of state only)
//   in_ctrl    upstream control bundle
//   in_data    upstream data bundle
//   out_valid  downstream entry valid
//   out_ready  downstream accepts
//   out_ctrl   control bundle, zero when out_valid is low
//   out_data   data bundle, holds its last value when out_valid is low
//   occupancy  number of entries held (0, 1 or 2)
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Encoding equals the number of held entries, so occupancy is the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_in_ready;
    logic              r_out_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic              w_accept;
    logic              w_consume;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;

    assign w_accept  = in_valid & r_in_ready;
    assign w_consume = r_out_valid & out_ready;

    // ---------------------------------------------------------------------
    // State register. in_ready and out_valid are kept as their own flops,
    // loaded from the next state, so neither output has any combinational
    // path from the handshake inputs.
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next != ST_FULL);
            r_out_valid <= (w_state_next != ST_EMPTY);
        end
    end

    // ---------------------------------------------------------------------
    // Next state and register load enables.
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;

        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_main_in = 1'b1;
                    w_state_next   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_consume) begin
                    w_load_main_in = 1'b1;
                end else if (w_consume) begin
                    w_state_next = ST_EMPTY;
                end else if (w_accept) begin
                    w_load_skid  = 1'b1;
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so nothing can be accepted.
                if (w_consume) begin
                    w_load_main_skid = 1'b1;
                    w_state_next     = ST_ONE;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase

        // A flush drops everything, including an entry offered this cycle.
        // Loads are suppressed so out_data keeps the last held value.
        if (Flush) begin
            w_state_next     = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Entry registers. Only reset clears them; flush leaves them alone.
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_ctrl  = r_out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;
    assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Directed and random checks for pipe_stage_skid. Inputs are driven just after
// the falling edge; outputs are sampled on the falling edge, half a period
// after the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;

    logic              Clk;
    logic              Rst;
    logic              Flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Flush    (Flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // {occupancy, in_ready, out_valid, out_ctrl}
    function automatic logic [11:0] status_vec(input logic [1:0] occ, input logic ir,
                                               input logic ov, input logic [7:0] ctl);
        return {occ, ir, ov, ctl};
    endfunction

    task automatic test_reset();
        Rst       = 1'b1;
        Flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'hFF;
        in_data   = 32'h1234_5678;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            if (c == 1) begin
                Rst      = 1'b0;
                in_valid = 1'b0;
            end
            checks++;
            if ({out_valid, out_ctrl, out_data, in_ready, occupancy} !==
                {1'b0, 8'h00, 32'h0, 1'b1, 2'd0}) begin
                errors++;
                $display("FAIL reset cyc%0d: got v=%b ctrl=%h data=%h ir=%b occ=%0d, want v=0 ctrl=00 data=0 ir=1 occ=0",
                         c, out_valid, out_ctrl, out_data, in_ready, occupancy);
            end
            $display("[reset] cycle %0d v=%b ir=%b occ=%0d", c, out_valid, in_ready, occupancy);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            in_ctrl  = 8'(i);
            @(negedge Clk);
            checks++;
            if ({out_valid, out_data, out_ctrl, occupancy} !== {1'b1, 32'(i), 8'(i), 2'd1}) begin
                errors++;
                $display("FAIL stream #%0d: got v=%b data=%0d ctrl=%h occ=%0d, want v=1 data=%0d ctrl=%h occ=1",
                         i, out_valid, out_data, out_ctrl, occupancy, i, 8'(i));
            end
            $display("[stream] out_data=%0d occ=%0d", out_data, occupancy);
        end
        in_valid = 1'b0;
        @(negedge Clk);
        checks++;
        if ({out_valid, out_ctrl, occupancy} !== {1'b0, 8'h00, 2'd0}) begin
            errors++;
            $display("FAIL stream_drain: got v=%b ctrl=%h occ=%0d, want v=0 ctrl=00 occ=0",
                     out_valid, out_ctrl, occupancy);
        end
    endtask

    task automatic test_back_pressure();
        logic        t_iv  [9];
        logic [31:0] t_id  [9];
        logic        t_ord [9];
        logic [1:0]  t_occ [9];
        logic [31:0] t_od  [9];
        logic        t_ir  [9];
        logic [7:0]  exp_ctl;
        t_iv  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        t_id  = '{1, 2, 3, 4, 4, 4, 5, 6, 0};
        t_ord = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
        t_occ = '{1, 1, 2, 2, 1, 1, 1, 1, 0};
        t_od  = '{1, 2, 2, 2, 3, 4, 5, 6, 6};
        t_ir  = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
        for (int c = 0; c < 9; c++) begin
            in_valid  = t_iv[c];
            in_data   = t_id[c];
            in_ctrl   = t_id[c][7:0];
            out_ready = t_ord[c];
            @(negedge Clk);
            exp_ctl = (t_occ[c] != 2'd0) ? t_od[c][7:0] : 8'h00;
            checks++;
            if ({occupancy, in_ready, out_valid, out_ctrl, out_data} !==
                {t_occ[c], t_ir[c], (t_occ[c] != 2'd0), exp_ctl, t_od[c]}) begin
                errors++;
                $display("FAIL backpressure cyc%0d: got occ=%0d ir=%b v=%b ctrl=%h data=%0d, want occ=%0d ir=%b v=%b ctrl=%h data=%0d",
                         c, occupancy, in_ready, out_valid, out_ctrl, out_data,
                         t_occ[c], t_ir[c], (t_occ[c] != 2'd0), exp_ctl, t_od[c]);
            end
            $display("[backpressure] cycle %0d occ=%0d ir=%b out_data=%0d", c, occupancy, in_ready, out_data);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 7;
        in_ctrl   = 8'h07;
        @(negedge Clk);
        in_data = 8;
        in_ctrl = 8'h08;
        @(negedge Clk);
        checks++;
        if ({occupancy, in_ready, out_data} !== {2'd2, 1'b0, 32'd7}) begin
            errors++;
            $display("FAIL flush_fill: got occ=%0d ir=%b data=%0d, want occ=2 ir=0 data=7",
                     occupancy, in_ready, out_data);
        end
        Flush   = 1'b1;
        in_data = 9;
        in_ctrl = 8'h09;
        @(negedge Clk);
        checks++;
        if (status_vec(occupancy, in_ready, out_valid, out_ctrl) !== status_vec(2'd0, 1'b1, 1'b0, 8'h00)) begin
            errors++;
            $display("FAIL flush_empty: got occ=%0d ir=%b v=%b ctrl=%h, want occ=0 ir=1 v=0 ctrl=00",
                     occupancy, in_ready, out_valid, out_ctrl);
        end
        $display("[flush] occ=%0d v=%b", occupancy, out_valid);
        Flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge Clk);
        checks++;
        if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL flush_stays_empty: got v=%b occ=%0d, want v=0 occ=0", out_valid, occupancy);
        end
        // Next entry through must be the new one, not any flushed one.
        in_valid = 1'b1;
        in_data  = 10;
        in_ctrl  = 8'h0A;
        @(negedge Clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data, out_ctrl} !== {1'b1, 32'd10, 8'h0A}) begin
            errors++;
            $display("FAIL flush_next: got v=%b data=%0d ctrl=%h, want v=1 data=10 ctrl=0a",
                     out_valid, out_data, out_ctrl);
        end
        @(negedge Clk);
        checks++;
        if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL flush_no_replay: got v=%b occ=%0d data=%0d, want v=0 occ=0",
                     out_valid, occupancy, out_data);
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 8'hA5;
        in_data   = 32'hDEAD_BEEF;
        @(negedge Clk);
        in_valid = 1'b0;
        in_ctrl  = 8'h3C;
        in_data  = 32'h0;
        checks++;
        if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'hA5, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL bubble_valid: got v=%b ctrl=%h data=%h, want v=1 ctrl=a5 data=deadbeef",
                     out_valid, out_ctrl, out_data);
        end
        $display("[bubble] v=%b ctrl=%h data=%h", out_valid, out_ctrl, out_data);
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk);
            checks++;
            if ({out_valid, out_ctrl, out_data} !== {1'b0, 8'h00, 32'hDEAD_BEEF}) begin
                errors++;
                $display("FAIL bubble_hold%0d: got v=%b ctrl=%h data=%h, want v=0 ctrl=00 data=deadbeef",
                         c, out_valid, out_ctrl, out_data);
            end
            $display("[bubble] v=%b ctrl=%h data=%h", out_valid, out_ctrl, out_data);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h55;
        in_data   = 32'hCAFE_0001;
        @(negedge Clk);
        in_data = 32'hCAFE_0002;
        @(negedge Clk);
        checks++;
        if (occupancy !== 2'd2) begin
            errors++;
            $display("FAIL resetmid_fill: got occ=%0d, want occ=2", occupancy);
        end
        Rst = 1'b1;
        @(negedge Clk);
        Rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_ctrl, out_data, in_ready, occupancy} !==
            {1'b0, 8'h00, 32'h0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL resetmid: got v=%b ctrl=%h data=%h ir=%b occ=%0d, want v=0 ctrl=00 data=0 ir=1 occ=0",
                     out_valid, out_ctrl, out_data, in_ready, occupancy);
        end
        // The skid entry must be gone too: releasing out_ready shows nothing.
        out_ready = 1'b1;
        @(negedge Clk);
        checks++;
        if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL resetmid_skid: got v=%b occ=%0d, want v=0 occ=0", out_valid, occupancy);
        end
        $display("[reset_mid] v=%b occ=%0d", out_valid, occupancy);
    endtask

    task automatic test_random();
        logic [39:0] q[$];
        logic [31:0] seq;
        logic [39:0] head;
        logic        m_acc;
        logic        m_con;
        int          n_out;
        seq   = 32'd1000;
        n_out = 0;
        Flush = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            Flush     = ($urandom_range(0, 99) < 5);
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 60);
            in_data   = seq;
            in_ctrl   = 8'($urandom);
            m_acc     = in_valid && (q.size() < 2);
            m_con     = out_ready && (q.size() > 0);
            if (Flush) begin
                q.delete();
            end else begin
                if (m_con) begin
                    void'(q.pop_front());
                    n_out++;
                end
                if (m_acc) q.push_back({in_ctrl, in_data});
            end
            if (m_acc) seq++;
            @(negedge Clk);
            head = (q.size() > 0) ? q[0] : 40'h0;
            checks++;
            if (status_vec(occupancy, in_ready, out_valid, out_ctrl) !==
                status_vec(2'(q.size()), (q.size() < 2), (q.size() > 0), head[39:32])) begin
                errors++;
                $display("FAIL random_status cyc%0d: got occ=%0d ir=%b v=%b ctrl=%h, want occ=%0d ir=%b v=%b ctrl=%h",
                         c, occupancy, in_ready, out_valid, out_ctrl,
                         q.size(), (q.size() < 2), (q.size() > 0), head[39:32]);
            end
            if (q.size() > 0) begin
                checks++;
                if (out_data !== head[31:0]) begin
                    errors++;
                    $display("FAIL random_data cyc%0d: got data=%0d, want data=%0d", c, out_data, head[31:0]);
                end
            end
        end
        Flush     = 1'b0;
        in_valid  = 1'b0;
        $display("[random] accepted=%0d consumed=%0d", seq - 32'd1000, n_out);
    endtask

    initial begin
        Rst       = 1'b1;
        Flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_bubble();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
